// File: rtl/regfile_n_pkg.sv
// regfile_n_pkg
//   Shared definitions for the register file and the pipeline stages
//   that talk to it (decode reads operands, writeback commits results).
//   - WIDTH_DEF / DEPTH_DEF / RST_VAL_DEF : default geometry and reset value
//   - sel_width()                         : register-select width for a depth
//   - word_t                              : one register word at default width
package regfile_n_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int DEPTH_DEF   = 8;
  localparam int RST_VAL_DEF = 0;

  // Select width for a given depth. Depth is a power of two >= 2, so this
  // is exact and never less than one bit.
  function automatic int sel_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef logic [WIDTH_DEF-1:0] word_t;

endpackage : regfile_n_pkg

// File: rtl/regfile_n_regn.sv
// regn
//   WIDTH-bit storage register with a recirculating write enable.
//   Holds its value unless en is high; reset forces RST_VAL and overrides en.
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   synchronous active-high reset
//     en   in   load enable
//     d    in   WIDTH  load data
//     q    out  WIDTH  stored value
module regn
  import regfile_n_pkg::*;
#(
  parameter int              WIDTH   = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : regn

// File: rtl/regfile_n.sv
// regfile_n
//   WIDTH x DEPTH register file: one synchronous write port, two
//   combinational read ports. Sits between decode (reads) and writeback
//   (writes).
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   synchronous active-high reset, loads RST_VAL everywhere
//     wr_en     in   write enable
//     wr_sel    in   SELW   destination register
//     wr_data   in   WIDTH  write data
//     rd_sel1   in   SELW   read port 1 register
//     rd_sel2   in   SELW   read port 2 register
//     rd_data1  out  WIDTH  read port 1 data (combinational)
//     rd_data2  out  WIDTH  read port 2 data (combinational)
//   Build option:
//     REGFILE_BYPASS_EN  when defined, a read of the register being written
//                        this cycle returns wr_data instead of the stored
//                        value (suppressed while rst is high).
module regfile_n
  import regfile_n_pkg::*;
#(
  parameter int               WIDTH   = WIDTH_DEF,
  parameter int               DEPTH   = DEPTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEF),
  localparam int              SELW    = sel_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SELW-1:0]  wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [SELW-1:0]  rd_sel1,
  input  logic [SELW-1:0]  rd_sel2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2
);

  logic [DEPTH-1:0] wr_onehot;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;

  // One-hot write decode; reset priority is handled inside each register.
  always_comb begin
    wr_onehot = '0;
    if (wr_en) begin
      wr_onehot[wr_sel] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    regn #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_regn (
      .clk (clk),
      .rst (rst),
      .en  (wr_onehot[i]),
      .d   (wr_data),
      .q   (regs[i])
    );
  end

  // DEPTH is a power of two, so every select value names a real register.
  assign stored1 = regs[rd_sel1];
  assign stored2 = regs[rd_sel2];

`ifdef REGFILE_BYPASS_EN
  // A write that reset is about to discard must not be forwarded.
  logic wr_live;
  assign wr_live  = wr_en && !rst;
  assign rd_data1 = (wr_live && (rd_sel1 == wr_sel)) ? wr_data : stored1;
  assign rd_data2 = (wr_live && (rd_sel2 == wr_sel)) ? wr_data : stored2;
`else
  assign rd_data1 = stored1;
  assign rd_data2 = stored2;
`endif

endmodule : regfile_n

// File: tb/tb_regfile_n.sv
module tb_regfile_n;

`ifdef REGFILE_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_sel = '0;
  logic [15:0] wr_data = '0;
  logic [2:0]  rd_sel1 = '0;
  logic [2:0]  rd_sel2 = '0;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;

  always #5 clk = ~clk;

  regfile_n dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .rd_sel1  (rd_sel1),
    .rd_sel2  (rd_sel2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  typedef struct {
    logic        r;
    logic        we;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference: the architectural contents of the eight registers.
  logic [15:0] mem [8];

  function automatic void add(input logic r, input logic we, input logic [2:0] ws,
                              input logic [15:0] wd, input logic [2:0] s1,
                              input logic [2:0] s2, input logic [15:0] e1,
                              input logic [15:0] e2);
    vec_t v;
    v.r = r; v.we = we; v.ws = ws; v.wd = wd;
    v.s1 = s1; v.s2 = s2; v.e1 = e1; v.e2 = e2;
    vecs.push_back(v);
  endfunction

  function automatic logic [15:0] model_rd(input logic r, input logic we, input logic [2:0] ws,
                                           input logic [15:0] wd, input logic [2:0] s);
    if (BP && we && !r && (s == ws)) return wd;
    return mem[s];
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  // Drive one cycle: apply inputs, sample outputs at the falling edge,
  // then advance through the rising edge and update the reference.
  task automatic cycle(input logic r, input logic we, input logic [2:0] ws,
                       input logic [15:0] wd, input logic [2:0] s1, input logic [2:0] s2,
                       output logic [15:0] o1, output logic [15:0] o2);
    rst = r; wr_en = we; wr_sel = ws; wr_data = wd; rd_sel1 = s1; rd_sel2 = s2;
    @(negedge clk);
    o1 = rd_data1;
    o2 = rd_data2;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 8; k++) mem[k] = 16'h0000;
    end else if (we) begin
      mem[ws] = wd;
    end
    #1;
  endtask

  initial begin
    logic [15:0] o1, o2, m1, m2;
    logic        r, we;
    logic [2:0]  ws, s1, s2;
    logic [15:0] wd;

    // Directed table; expectations are the outputs during that cycle.
    for (int i = 0; i < 8; i++)
      add(0, 1, 3'(i), 16'hBEEF, 3'(i), 3'(i), BP ? 16'hBEEF : 16'h0000, BP ? 16'hBEEF : 16'h0000);
    add(1, 0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'hBEEF, 16'hBEEF);
    add(0, 0, 3'd0, 16'h0000, 3'd0, 3'd1, 16'h0000, 16'h0000);
    add(0, 0, 3'd0, 16'h0000, 3'd2, 3'd3, 16'h0000, 16'h0000);
    add(0, 0, 3'd0, 16'h0000, 3'd4, 3'd5, 16'h0000, 16'h0000);
    add(0, 0, 3'd0, 16'h0000, 3'd6, 3'd7, 16'h0000, 16'h0000);
    add(0, 1, 3'd3, 16'h1234, 3'd3, 3'd4, BP ? 16'h1234 : 16'h0000, 16'h0000);
    add(0, 0, 3'd0, 16'h0000, 3'd3, 3'd4, 16'h1234, 16'h0000);
    add(0, 1, 3'd7, 16'hA5A5, 3'd7, 3'd7, BP ? 16'hA5A5 : 16'h0000, BP ? 16'hA5A5 : 16'h0000);
    add(0, 0, 3'd0, 16'h0000, 3'd7, 3'd7, 16'hA5A5, 16'hA5A5);
    add(0, 1, 3'd2, 16'h0001, 3'd2, 3'd0, BP ? 16'h0001 : 16'h0000, 16'h0000);
    add(0, 1, 3'd2, 16'h00FF, 3'd2, 3'd3, BP ? 16'h00FF : 16'h0001, 16'h1234);
    add(0, 0, 3'd0, 16'h0000, 3'd2, 3'd7, 16'h00FF, 16'hA5A5);
    add(0, 1, 3'd5, 16'h5555, 3'd5, 3'd5, BP ? 16'h5555 : 16'h0000, BP ? 16'h5555 : 16'h0000);
    add(1, 1, 3'd5, 16'hFFFF, 3'd5, 3'd2, 16'h5555, 16'h00FF);
    add(0, 0, 3'd0, 16'h0000, 3'd5, 3'd2, 16'h0000, 16'h0000);
    add(0, 1, 3'd1, 16'h1111, 3'd1, 3'd1, BP ? 16'h1111 : 16'h0000, BP ? 16'h1111 : 16'h0000);
    add(0, 1, 3'd1, 16'h2222, 3'd1, 3'd0, BP ? 16'h2222 : 16'h1111, 16'h0000);
    add(0, 0, 3'd0, 16'h0000, 3'd1, 3'd1, 16'h2222, 16'h2222);
    add(0, 1, 3'd6, 16'h6666, 3'd6, 3'd1, BP ? 16'h6666 : 16'h0000, 16'h2222);
    add(0, 0, 3'd0, 16'h0000, 3'd6, 3'd5, 16'h6666, 16'h0000);

    // Initial reset: contents before it are undefined, so nothing is checked.
    @(posedge clk); #1;
    cycle(1, 0, 0, 0, 0, 0, o1, o2);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].we, vecs[i].ws, vecs[i].wd, vecs[i].s1, vecs[i].s2, o1, o2);
      check("table_rd1", i, o1, vecs[i].e1);
      check("table_rd2", i, o2, vecs[i].e2);
    end

    // Hold: no writes while select and data toggle; the array must not move.
    for (int i = 0; i < 10; i++) begin
      ws = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      s1 = 3'($urandom_range(0, 7));
      s2 = 3'($urandom_range(0, 7));
      m1 = mem[s1];
      m2 = mem[s2];
      cycle(0, 0, ws, wd, s1, s2, o1, o2);
      check("hold_rd1", i, o1, m1);
      check("hold_rd2", i, o2, m2);
    end
    for (int i = 0; i < 8; i += 2) begin
      m1 = mem[i];
      m2 = mem[i + 1];
      cycle(0, 0, 3'(i), 16'hDEAD, 3'(i), 3'(i + 1), o1, o2);
      check("hold_final1", i, o1, m1);
      check("hold_final2", i, o2, m2);
    end

    // Randomised traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 24) == 0);
      we = ($urandom_range(0, 3) != 0);
      ws = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      s1 = ($urandom_range(0, 3) == 0) ? ws : 3'($urandom_range(0, 7));
      s2 = ($urandom_range(0, 3) == 0) ? s1 : 3'($urandom_range(0, 7));
      m1 = model_rd(r, we, ws, wd, s1);
      m2 = model_rd(r, we, ws, wd, s2);
      cycle(r, we, ws, wd, s1, s2, o1, o2);
      check("rand_rd1", i, o1, m1);
      check("rand_rd2", i, o2, m2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_regfile_n
